// File: rtl/cpu_pkg.sv
// cpu_pkg: types and constants shared by the instruction-side loader.
//   ld_state_e  : loader state (LOAD / RUN / HALT)
//   NOP_INST    : word returned for masked reads (sll $0,$0,0)
//   PROG_WORDS_DEF : default program length (sort program ends at 8'h11)
//   NUM_LANES / LANE_W / lane_lsb() : byte-lane geometry, big-endian
package cpu_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } ld_state_e;

  localparam logic [31:0] NOP_INST       = 32'h0000_0000;
  localparam int          PROG_WORDS_DEF = 18;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 2;
  localparam int BYTE_W    = 8;

  // Lane 0 is the most significant byte of the word.
  localparam int LANE0_LSB = 24;
  localparam int LANE1_LSB = 16;
  localparam int LANE2_LSB = 8;
  localparam int LANE3_LSB = 0;

  function automatic int lane_lsb(input logic [LANE_W-1:0] lane);
    return (NUM_LANES - 1 - int'(lane)) * BYTE_W;
  endfunction

endpackage

// File: rtl/inst_loader_mem_byte_word_assembler.sv
// byte_word_assembler: packs a big-endian byte stream into 32-bit words.
//   Clk, Clr    : clock, async active-high clear
//   restart     : synchronous clear when a new download begins
//   accept      : in_byte is taken on this edge
//   in_byte     : program byte
//   word_valid  : combinational pulse, high on the cycle the lane-3 byte is taken
//   word        : assembled word (includes the current lane-3 byte)
//   lane        : next lane to be filled
module byte_word_assembler
  import cpu_pkg::*;
(
  input  logic              Clk,
  input  logic              Clr,
  input  logic              restart,
  input  logic              accept,
  input  logic [BYTE_W-1:0] in_byte,
  output logic              word_valid,
  output logic [31:0]       word,
  output logic [LANE_W-1:0] lane
);

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);

  // Lanes 0..2 shift in from the right, so after three bytes the
  // first one sits in [23:16] and lines up with [31:24] of the word.
  logic [23:0] hold;

  assign word_valid = accept && (lane == LAST_LANE);
  assign word       = {hold, in_byte};

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      lane <= '0;
      hold <= '0;
    end else if (restart) begin
      lane <= '0;
      hold <= '0;
    end else if (accept) begin
      if (lane == LAST_LANE) begin
        lane <= '0;
        hold <= '0;
      end else begin
        lane <= lane + LANE_W'(1);
        hold <= {hold[15:0], in_byte};
      end
    end
  end

endmodule

// File: rtl/inst_loader_mem.sv
// inst_loader_mem: instruction memory for the single-cycle sort CPU.
// Downloads PROG_WORDS words over a byte valid/ready stream, then raises
// `over` to release the PC unit and serves instructions combinationally.
//   Clk, Clr      : clock, async active-high reset
//   PC            : instruction word address
//   inst          : mem[PC] when loaded and in range, NOP otherwise
//   over          : program loaded, CPU may run (registered)
//   sortover      : run finished, go to HALT
//   reload        : start a new download (HALT only)
//   in_valid/in_byte/in_ready : program byte stream
//   loaded_words  : complete words written since the last load start
module inst_loader_mem
  import cpu_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int PROG_WORDS = PROG_WORDS_DEF
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic [ADDR_W-1:0] PC,
  output logic [31:0]       inst,
  output logic              over,
  input  logic              sortover,
  input  logic              reload,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic [ADDR_W:0]   loaded_words
);

  localparam int              DEPTH     = 2**ADDR_W;
  localparam logic [ADDR_W:0] LAST_WORD = (ADDR_W+1)'(PROG_WORDS - 1);

  ld_state_e state, state_nxt;

  logic [31:0]       mem [DEPTH];
  logic              accept, restart, word_valid, hit;
  logic [31:0]       word;
  logic [LANE_W-1:0] lane;

  // in_ready is 0 in HALT, so a reload cycle can never also take a byte.
  assign accept  = in_valid && in_ready;
  assign restart = (state == HALT) && reload;

  byte_word_assembler u_asm (
    .Clk        (Clk),
    .Clr        (Clr),
    .restart    (restart),
    .accept     (accept),
    .in_byte    (in_byte),
    .word_valid (word_valid),
    .word       (word),
    .lane       (lane)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (word_valid && (loaded_words == LAST_WORD)) state_nxt = RUN;
      RUN:     if (sortover) state_nxt = HALT;
      HALT:    if (reload)   state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // over / in_ready are flopped from the next state so they change on
  // the same edge as the state itself and are glitch-free outputs.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state        <= LOAD;
      over         <= 1'b0;
      in_ready     <= 1'b1;
      loaded_words <= '0;
    end else begin
      state    <= state_nxt;
      over     <= (state_nxt != LOAD);
      in_ready <= (state_nxt == LOAD);
      if (restart)
        loaded_words <= '0;
      else if (word_valid)
        loaded_words <= loaded_words + (ADDR_W+1)'(1);
    end
  end

  // Storage is not reset; stale words stay hidden by the read mask.
  always_ff @(posedge Clk) begin
    if (word_valid)
      mem[loaded_words[ADDR_W-1:0]] <= word;
  end

  assign hit  = over && ({1'b0, PC} < loaded_words);
  assign inst = hit ? mem[PC] : NOP_INST;

endmodule

// File: tb/tb_inst_loader_mem.sv
module tb_inst_loader_mem;
  localparam int ADDR_W = 8;
  localparam int PW     = 18;

  logic              Clk = 1'b0;
  logic              Clr = 1'b1;
  logic [ADDR_W-1:0] PC = '0;
  logic [31:0]       inst;
  logic              over;
  logic              sortover = 1'b0;
  logic              reload = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_byte = '0;
  logic              in_ready;
  logic [ADDR_W:0]   loaded_words;

  inst_loader_mem #(.ADDR_W(ADDR_W), .PROG_WORDS(PW)) dut (
    .Clk          (Clk),
    .Clr          (Clr),
    .PC           (PC),
    .inst         (inst),
    .over         (over),
    .sortover     (sortover),
    .reload       (reload),
    .in_valid     (in_valid),
    .in_byte      (in_byte),
    .in_ready     (in_ready),
    .loaded_words (loaded_words)
  );

  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_err = 0;
  int acc_cnt = 0;

  // reference model of what the CPU should see
  logic [31:0] model_mem [PW];
  int          model_cnt = 0;
  bit          model_over = 1'b0;
  logic [31:0] sb_q [$];

  always @(posedge Clk)
    if (!Clr && in_valid && in_ready) acc_cnt <= acc_cnt + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_inst(input int pc);
    if (model_over && pc < model_cnt) return model_mem[pc];
    return 32'h0;
  endfunction

  // push expectation when PC is driven, pop when inst is sampled
  task automatic rd(input int pc);
    PC = ADDR_W'(pc);
    sb_q.push_back(model_inst(pc));
    @(negedge Clk);
    chk($sformatf("inst[%0d]", pc), {32'h0, inst}, {32'h0, sb_q.pop_front()});
  endtask

  task automatic do_reset();
    @(posedge Clk); #1;
    Clr = 1'b1; in_valid = 1'b0; reload = 1'b0; sortover = 1'b0;
    model_over = 1'b0; model_cnt = 0;
    #1;
    chk("rst_over",  {63'h0, over},     64'h0);
    chk("rst_ready", {63'h0, in_ready}, 64'h1);
    chk("rst_lw",    {55'h0, loaded_words}, 64'h0);
    rd(0);
    @(posedge Clk); #1;
    Clr = 1'b0;
  endtask

  // streams PW words base+i; optional 5-cycle stall after 2 bytes of
  // word stall_w; optional extra cycles with in_valid held high
  task automatic load_prog(input logic [31:0] base, input int stall_w, input int extra);
    int a0;
    logic [31:0] wd;
    a0 = acc_cnt;
    for (int w = 0; w < PW; w++) begin
      wd = base + 32'(w);
      for (int b = 0; b < 4; b++) begin
        if (w == stall_w && b == 2) begin
          in_valid = 1'b0;
          repeat (5) @(posedge Clk);
          #1;
          chk("stall_lw", {55'h0, loaded_words}, 64'(w));
        end
        in_valid = 1'b1;
        in_byte  = wd[31-8*b -: 8];
        @(posedge Clk); #1;
        chk("over_step", {63'h0, over}, {63'h0, (w == PW-1 && b == 3)});
        if (b == 3) chk("lw_step", {55'h0, loaded_words}, 64'(w + 1));
      end
      model_mem[w] = wd;
    end
    in_byte = 8'hFF;
    repeat (extra) @(posedge Clk);
    #1;
    in_valid = 1'b0;
    model_cnt = PW; model_over = 1'b1;
    chk("acc_bytes", 64'(acc_cnt - a0), 64'(PW*4));
    chk("ready_run", {63'h0, in_ready}, 64'h0);
  endtask

  initial begin
    int a0;
    // basic load, one byte per cycle
    do_reset();
    load_prog(32'h2008_0000, -1, 0);
    rd(5); rd(18); rd(0); rd(17);

    // RUN: in_valid stuck high, reload pulsed -> nothing changes
    @(posedge Clk); #1;
    a0 = acc_cnt;
    in_valid = 1'b1; in_byte = 8'h5A; reload = 1'b1;
    @(posedge Clk); #1;
    reload = 1'b0;
    @(posedge Clk); #1;
    in_valid = 1'b0;
    chk("run_ready", {63'h0, in_ready}, 64'h0);
    chk("run_over",  {63'h0, over},     64'h1);
    chk("run_acc",   64'(acc_cnt - a0), 64'h0);
    chk("run_lw",    {55'h0, loaded_words}, 64'(PW));
    rd(5);

    // HALT, then reload together with in_valid
    sortover = 1'b1;
    @(posedge Clk); #1;
    sortover = 1'b0;
    chk("halt_over",  {63'h0, over},     64'h1);
    chk("halt_ready", {63'h0, in_ready}, 64'h0);
    a0 = acc_cnt;
    reload = 1'b1; in_valid = 1'b1; in_byte = 8'hAA;
    @(posedge Clk); #1;
    reload = 1'b0; in_valid = 1'b0;
    model_over = 1'b0; model_cnt = 0;
    chk("rl_over",  {63'h0, over},     64'h0);
    chk("rl_lw",    {55'h0, loaded_words}, 64'h0);
    chk("rl_ready", {63'h0, in_ready}, 64'h1);
    chk("rl_acc",   64'(acc_cnt - a0), 64'h0);
    rd(0);

    // second program: stall in word 3, extra bytes after the last word
    load_prog(32'h1122_0000, 3, 10);
    rd(3); rd(5); rd(17); rd(18); rd(255);

    // Clr in RUN
    @(posedge Clk); #1;
    Clr = 1'b1; #1;
    model_over = 1'b0; model_cnt = 0;
    chk("clr_run_over", {63'h0, over}, 64'h0);
    rd(3);
    @(posedge Clk); #1;
    Clr = 1'b0;

    // Clr after 6 bytes discards the partial word
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_byte = 8'hD0 + 8'(i);
      @(posedge Clk); #1;
    end
    in_valid = 1'b0;
    chk("part_lw", {55'h0, loaded_words}, 64'h1);
    do_reset();
    load_prog(32'hC0DE_0100, -1, 0);
    rd(0); rd(1); rd(16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
